// File: rtl/rr_muxnway.sv
// ============================================================================
// Module   : rr_muxnway
// Purpose  : Registered N-channel mux with round-robin arbitration and
//            valid/ready handshakes on every input and on the output.
//            Define RRMUX_FIXED_PRIO_EN for a fixed-priority (channel 0 first)
//            search instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_muxnway #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int LW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] inp,
    input  logic [CHANNELS-1:0]       inp_valid,
    output logic [CHANNELS-1:0]       inp_ready,
    output logic [WIDTH-1:0]          out,
    output logic [LW-1:0]             out_line,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [LW-1:0] c_LAST = LW'(CHANNELS - 1);

    logic [WIDTH-1:0]    r_out;
    logic [LW-1:0]       r_line;
    logic                r_valid;

    logic                w_load;
    logic [LW-1:0]       w_start;
    logic                w_found;
    logic [LW-1:0]       w_gidx;
    logic [WIDTH-1:0]    w_data;
    logic [CHANNELS-1:0] w_ready;
    logic                w_take;

    assign w_load = !r_valid || out_ready;

`ifdef RRMUX_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [LW-1:0] r_ptr;
    logic [LW-1:0] w_ptr_next;

    assign w_start    = r_ptr;
    assign w_ptr_next = (w_gidx == c_LAST) ? '0 : (w_gidx + LW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_take) begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    // Walk the channels from the start pointer, wrapping at CHANNELS-1,
    // and stop at the first valid one.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_data  = '0;
        w_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            int idx;
            idx = int'(w_start) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!w_found && inp_valid[idx]) begin
                w_found      = 1'b1;
                w_gidx       = LW'(idx);
                w_data       = inp[idx*WIDTH +: WIDTH];
                w_ready[idx] = w_load;
            end
        end
    end

    assign w_take    = w_found && w_load;
    assign inp_ready = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_line  <= '0;
            r_valid <= 1'b0;
        end else if (w_take) begin
            r_out   <= w_data;
            r_line  <= w_gidx;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            // Drain with nothing to replace it: data and line hold.
            r_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_line  = r_line;
    assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_muxnway.sv
// Directed + randomised bench for rr_muxnway (4-channel and 3-channel instances).
`default_nettype none

module tb_rr_muxnway;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int C3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [C*W-1:0]  inp;
    logic [C-1:0]    inp_valid;
    logic [C-1:0]    inp_ready;
    logic [W-1:0]    out;
    logic [1:0]      out_line;
    logic            out_valid;
    logic            out_ready;

    logic [C3*W-1:0] inp3;
    logic [C3-1:0]   inp_valid3;
    logic [C3-1:0]   inp_ready3;
    logic [W-1:0]    out3;
    logic [1:0]      out_line3;
    logic            out_valid3;
    logic            out_ready3;

    rr_muxnway #(.WIDTH(W), .CHANNELS(C)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .inp(inp), .inp_valid(inp_valid),
        .inp_ready(inp_ready), .out(out), .out_line(out_line),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_muxnway #(.WIDTH(W), .CHANNELS(C3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .inp(inp3), .inp_valid(inp_valid3),
        .inp_ready(inp_ready3), .out(out3), .out_line(out_line3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    int checks = 0;
    int errors = 0;

    logic [17:0] sb[$];
    logic [1:0]  m_ptr   = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_out   = '0;
    logic [1:0]  m_line  = '0;

    function automatic int find_grant(input logic [3:0] v, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (start + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        int         g;
        int         st;
        logic       ld;
        logic [3:0] exp_rdy;
        logic       pushed;
        #1;
`ifdef RRMUX_FIXED_PRIO_EN
        st = 0;
`else
        st = int'(m_ptr);
`endif
        ld      = !m_valid || out_ready;
        g       = find_grant(inp_valid, st, C);
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, "_rdy"}, 32'(inp_ready), 32'(exp_rdy));
        pushed = 1'b0;
        if (exp_rdy != 4'b0) begin
            sb.push_back({2'(g), inp[g*W +: W]});
            m_ptr   = (g == C-1) ? 2'd0 : 2'(g + 1);
            m_valid = 1'b1;
            pushed  = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (pushed) begin
            logic [17:0] e;
            e      = sb.pop_front();
            m_line = e[17:16];
            m_out  = e[15:0];
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk({tag, "_out"},  32'(out),      32'(m_out));
            chk({tag, "_line"}, 32'(out_line), 32'(m_line));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        inp        = '0;
        inp_valid  = '0;
        out_ready  = 1'b0;
        inp3       = '0;
        inp_valid3 = '0;
        out_ready3 = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out",   32'(out),       32'd0);
        chk("rst_line",  32'(out_line),  32'd0);
        chk("rst_ready", 32'(inp_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        out_ready = 1'b1;
        repeat (3) step("idle");

        // Load 16'h00FF from channel 3 and hold it, then reset mid-cycle.
        inp       = {16'h00FF, 16'h5555, 16'hFFFF, 16'h0000};
        inp_valid = 4'b1000;
        out_ready = 1'b0;
        step("load3");
        inp_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_out",   32'(out),       32'd0);
        chk("arst_line",  32'(out_line),  32'd0);
        chk("arst_ready", 32'(inp_ready), 32'd0);
        m_valid = 1'b0;
        m_ptr   = '0;
        m_out   = '0;
        m_line  = '0;
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step("idle2");

        inp_valid = 4'b1111;
        repeat (5) step("sweep");

        inp_valid = 4'b1010;
        repeat (4) step("skip");

        inp_valid = 4'b0100;
        step("bp_load");
        inp_valid = 4'b1111;
        out_ready = 1'b0;
        repeat (3) step("bp_hold");
        out_ready = 1'b1;
        step("bp_rel");

        inp_valid = 4'b0101;
        repeat (4) step("prio");
        inp_valid = 4'b0100;
        repeat (2) step("prio_ch2");

        for (int i = 0; i < 40; i++) begin
            inp       = {$urandom, $urandom};
            inp_valid = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end
        inp_valid = '0;
        out_ready = 1'b1;
        step("drain");

        // Three-channel instance: wrap must skip the nonexistent index 3.
        inp3       = {16'h3333, 16'h2222, 16'h1111};
        inp_valid3 = 3'b111;
        out_ready3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int ln;
`ifdef RRMUX_FIXED_PRIO_EN
            ln = 0;
`else
            ln = k % 3;
`endif
            #1;
            chk("wrap3_rdy", 32'(inp_ready3), 32'(1 << ln));
            @(posedge clk);
            #1;
            chk("wrap3_valid", 32'(out_valid3), 32'd1);
            chk("wrap3_line",  32'(out_line3),  32'(ln));
            chk("wrap3_out",   32'(out3),       32'(inp3[ln*W +: W]));
            @(negedge clk);
        end
        inp_valid3 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
